lsu_mem_master: RTL and testbench

// - Initiator side of the core's word-wide data-memory strobe interface (RDSTB/WRSTB/ADDR/DATA).
// - Accepts one byte-addressed load/store from the execute stage and issues word strobes to the memory.
// - Handles LB/LH/LW/LBU/LHU and SB/SH/SW; sub-word stores via read-modify-write; sign/zero extension.
// - One request in flight; flags misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_mem_master_pkg.sv | 19 +
 rtl/lsu_mem_master_if.sv | 29 ++
 rtl/lsu_mem_master_align.sv | 40 ++++
 rtl/lsu_mem_master.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the load/store unit: RV32 funct3 widths and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_WAIT,
      MERGE,
      WR,
      RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake from execute plus the word-wide strobe bus to data memory.
interface lsu_mem_master_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        M_RDSTB;
   logic        M_WRSTB;
   logic [31:0] M_ADDR;
   logic [31:0] M_DATA_O;
   logic [31:0] M_DATA_I;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, M_DATA_I,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, M_RDSTB, M_WRSTB, M_ADDR, M_DATA_O
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, M_DATA_I,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, M_RDSTB, M_WRSTB, M_ADDR, M_DATA_O
   );

endinterface

// File: rtl/lsu_mem_master_align.sv
// Combinational lane logic: load extract with sign/zero extension, and sub-word store merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{lane, 3'b000} +: 8];
   assign half_sel = word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = word;
      case (funct3)
         F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ld_data = {24'h0, byte_sel};
         F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ld_data = {16'h0, half_sel};
         default: ld_data = word;
      endcase
   end

   // Only B/H stores reach the merge path; every other lane of the read word is kept.
   always_comb begin
      st_word = word;
      case (funct3)
         F3_B:    st_word[{lane, 3'b000} +: 8]    = wdata[7:0];
         F3_H:    st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: st_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request in flight, sub-word stores by read-modify-write.
// Errors (misalignment, range, bad funct3) respond without ever strobing memory.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned DMSIZE      = 1024,
   parameter logic [31:0] BASEADDRESS = 32'h0000_0000
) (
   input  logic ACLK,
   input  logic WRSTB,
   lsu_mem_master_if.master bus
);

   lsu_state_t  state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] merged_q;

   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        m_rdstb;
   logic        m_wrstb;
   logic [31:0] m_addr;
   logic [31:0] m_data_o;

   logic [31:0] word_addr;
   logic [32:0] word_limit;
   logic        req_err;
   logic [31:0] ld_data;
   logic [31:0] st_word;

   assign word_addr  = {2'b00, bus.req_addr[31:2]};
   assign word_limit = {1'b0, BASEADDRESS} + 33'(DMSIZE);

   always_comb begin
      req_err = 1'b0;
      case (bus.req_funct3)
         F3_B:    req_err = 1'b0;
         F3_H:    req_err = bus.req_addr[0];
         F3_W:    req_err = |bus.req_addr[1:0];
         F3_BU:   req_err = bus.req_we;
         F3_HU:   req_err = bus.req_we | bus.req_addr[0];
         default: req_err = 1'b1;
      endcase
      // 33-bit compare so a window ending at the top of the address space cannot wrap.
      if ((word_addr < BASEADDRESS) || ({1'b0, word_addr} >= word_limit))
         req_err = 1'b1;
   end

   lsu_align u_align (
      .funct3  (f3_q),
      .lane    (lane_q),
      .word    (bus.M_DATA_I),
      .wdata   (wdata_q),
      .ld_data (ld_data),
      .st_word (st_word)
   );

   always_ff @(posedge ACLK) begin
      if (WRSTB) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= F3_W;
         lane_q    <= 2'b00;
         wdata_q   <= 32'h0;
         merged_q  <= 32'h0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         m_rdstb   <= 1'b0;
         m_wrstb   <= 1'b0;
         m_addr    <= 32'h0;
         m_data_o  <= 32'h0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid && req_ready) begin
               we_q      <= bus.req_we;
               f3_q      <= bus.req_funct3;
               lane_q    <= bus.req_addr[1:0];
               wdata_q   <= bus.req_wdata;
               req_ready <= 1'b0;
               if (req_err) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                  m_wrstb  <= 1'b1;
                  m_addr   <= word_addr;
                  m_data_o <= bus.req_wdata;
                  state    <= WR;
               end else begin
                  m_rdstb <= 1'b1;
                  m_addr  <= word_addr;
                  state   <= RD;
               end
            end
            RD: begin
               m_rdstb <= 1'b0;
               state   <= RD_WAIT;
            end
            RD_WAIT: begin
               if (we_q) begin
                  merged_q <= st_word;
                  state    <= MERGE;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ld_data;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end
            end
            MERGE: begin
               m_wrstb  <= 1'b1;
               m_data_o <= merged_q;
               state    <= WR;
            end
            WR: begin
               m_wrstb   <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_err   = rsp_err;
   assign bus.M_RDSTB   = m_rdstb;
   assign bus.M_WRSTB   = m_wrstb;
   assign bus.M_ADDR    = m_addr;
   assign bus.M_DATA_O  = m_data_o;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a 1024-word registered-read memory model.
module tb_lsu_mem_master;
   import lsu_pkg::*;

   logic ACLK  = 1'b0;
   logic WRSTB = 1'b1;
   always #5 ACLK = ~ACLK;

   lsu_mem_master_if bus ();

   lsu_mem_master #(.DMSIZE(1024), .BASEADDRESS(32'h0)) dut (
      .ACLK  (ACLK),
      .WRSTB (WRSTB),
      .bus   (bus)
   );

   logic [31:0] mem [0:1023];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [31:0] pl_dat = '0;

   always @(posedge ACLK) begin
      if (pl_en)
         mem[pl_addr] <= pl_dat;
      else if (bus.M_WRSTB && bus.M_ADDR < 32'd1024)
         mem[bus.M_ADDR[9:0]] <= bus.M_DATA_O;
      if (bus.M_RDSTB)
         bus.M_DATA_I <= mem[bus.M_ADDR[9:0]];
   end

   int n_assert = 0;
   int n_fail   = 0;

   int          rsp_cyc, rd_cnt, wr_cnt, rd_cyc, wr_cyc, both_hi;
   logic [31:0] rsp_dat, rd_addr, wr_dat;
   logic        rsp_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge ACLK);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(posedge ACLK);
      #1 pl_en = 1'b0;
   endtask

   // Observe cycles 1..20 after an accept edge, recording strobes and the response.
   task automatic watch();
      rsp_cyc = -1; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1; both_hi = 0;
      rsp_dat = 'x; rsp_e = 1'bx; rd_addr = 'x; wr_dat = 'x;
      for (int n = 1; n <= 20; n++) begin
         @(negedge ACLK);
         if (bus.M_RDSTB && bus.M_WRSTB) both_hi++;
         if (bus.M_RDSTB) begin rd_cnt++; rd_cyc = n; rd_addr = bus.M_ADDR; end
         if (bus.M_WRSTB) begin wr_cnt++; wr_cyc = n; wr_dat = bus.M_DATA_O; end
         if (bus.rsp_valid) begin
            rsp_cyc = n; rsp_dat = bus.rsp_rdata; rsp_e = bus.rsp_err;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
      @(negedge ACLK);
      check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge ACLK);
      #1 bus.req_valid = 1'b0;
      watch();
   endtask

   task automatic expect_op(input string tag, input int cyc, input logic [31:0] rd,
                            input logic err, input int nrd, input int nwr);
      check({tag, ".cycle"}, 32'(rsp_cyc), 32'(cyc));
      check({tag, ".rdata"}, rsp_dat, rd);
      check({tag, ".err"},   32'(rsp_e), 32'(err));
      check({tag, ".nrd"},   32'(rd_cnt), 32'(nrd));
      check({tag, ".nwr"},   32'(wr_cnt), 32'(nwr));
      check({tag, ".both"},  32'(both_hi), 32'd0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
      bus.req_addr = '0; bus.req_wdata = '0;

      repeat (2) @(negedge ACLK);
      check("rst.ready", 32'(bus.req_ready), 32'd1);
      check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst.strobes", {30'd0, bus.M_RDSTB, bus.M_WRSTB}, 32'd0);
      check("rst.addr", bus.M_ADDR, 32'h0);
      WRSTB = 1'b0;

      preload(10'd4, 32'hDEAD_BEEF);
      run("lw", 1'b0, F3_W, 32'h10, 32'h0);
      expect_op("lw", 3, 32'hDEAD_BEEF, 1'b0, 1, 0);
      check("lw.rd_cycle", 32'(rd_cyc), 32'd1);
      check("lw.rd_addr", rd_addr, 32'd4);

      preload(10'd4, 32'h80FF_7F01);
      run("lb", 1'b0, F3_B, 32'h13, 32'h0);
      expect_op("lb", 3, 32'hFFFF_FF80, 1'b0, 1, 0);
      run("lbu", 1'b0, F3_BU, 32'h13, 32'h0);
      expect_op("lbu", 3, 32'h0000_0080, 1'b0, 1, 0);
      run("lh", 1'b0, F3_H, 32'h12, 32'h0);
      expect_op("lh", 3, 32'hFFFF_80FF, 1'b0, 1, 0);
      run("lhu", 1'b0, F3_HU, 32'h10, 32'h0);
      expect_op("lhu", 3, 32'h0000_7F01, 1'b0, 1, 0);
      run("lb0", 1'b0, F3_B, 32'h10, 32'h0);
      expect_op("lb0", 3, 32'h0000_0001, 1'b0, 1, 0);

      preload(10'd4, 32'h1122_3344);
      run("sb", 1'b1, F3_B, 32'h11, 32'h0000_00AA);
      expect_op("sb", 5, 32'h0, 1'b0, 1, 1);
      check("sb.wdata", wr_dat, 32'h1122_AA44);
      check("sb.wr_cycle", 32'(wr_cyc), 32'd4);
      check("sb.mem", mem[4], 32'h1122_AA44);
      run("sh", 1'b1, F3_H, 32'h12, 32'h0000_BEEF);
      expect_op("sh", 5, 32'h0, 1'b0, 1, 1);
      check("sh.mem", mem[4], 32'hBEEF_AA44);

      run("sw_mis", 1'b1, F3_W, 32'h2, 32'h1234_5678);
      expect_op("sw_mis", 1, 32'h0, 1'b1, 0, 0);
      run("lw_oor", 1'b0, F3_W, 32'h0000_1000, 32'h0);
      expect_op("lw_oor", 1, 32'h0, 1'b1, 0, 0);
      run("lh_mis", 1'b0, F3_H, 32'h11, 32'h0);
      expect_op("lh_mis", 1, 32'h0, 1'b1, 0, 0);
      run("f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
      expect_op("f3_011", 1, 32'h0, 1'b1, 0, 0);
      run("sbu", 1'b1, F3_BU, 32'h10, 32'h0);
      expect_op("sbu", 1, 32'h0, 1'b1, 0, 0);
      preload(10'd1023, 32'h0BAD_F00D);
      run("lw_top", 1'b0, F3_W, 32'h0000_0FFC, 32'h0);
      expect_op("lw_top", 3, 32'h0BAD_F00D, 1'b0, 1, 0);

      // SW then LW to the same word with req_valid held high throughout.
      @(negedge ACLK);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
      bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFE_F00D;
      @(posedge ACLK);
      #1 bus.req_we = 1'b0;
      @(negedge ACLK);
      check("b2b.busy1", 32'(bus.req_ready), 32'd0);
      check("b2b.wrstb", 32'(bus.M_WRSTB), 32'd1);
      @(negedge ACLK);
      check("b2b.busy2", 32'(bus.req_ready), 32'd0);
      check("b2b.sw_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
      @(negedge ACLK);
      check("b2b.ready", 32'(bus.req_ready), 32'd1);
      @(posedge ACLK);
      #1 bus.req_valid = 1'b0;
      watch();
      expect_op("b2b.lw", 3, 32'hCAFE_F00D, 1'b0, 1, 0);

      // Reset during MERGE of an SH must abort the write and restore reset outputs.
      preload(10'd8, 32'h5555_6666);
      @(negedge ACLK);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
      bus.req_addr = 32'h22; bus.req_wdata = 32'h0000_BEEF;
      @(posedge ACLK);
      #1 bus.req_valid = 1'b0;
      @(negedge ACLK);
      check("rstm.rdstb", 32'(bus.M_RDSTB), 32'd1);
      repeat (2) @(negedge ACLK);
      WRSTB = 1'b1;
      @(negedge ACLK);
      WRSTB = 1'b0;
      check("rstm.ready", 32'(bus.req_ready), 32'd1);
      check("rstm.rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      check("rstm.rdata", bus.rsp_rdata, 32'h0);
      check("rstm.strobes", {30'd0, bus.M_RDSTB, bus.M_WRSTB}, 32'd0);
      check("rstm.addr", bus.M_ADDR, 32'h0);
      check("rstm.data_o", bus.M_DATA_O, 32'h0);
      wr_cnt = 0; rsp_cyc = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge ACLK);
         if (bus.M_WRSTB) wr_cnt++;
         if (bus.rsp_valid) rsp_cyc++;
      end
      check("rstm.no_wr", 32'(wr_cnt), 32'd0);
      check("rstm.no_rsp", 32'(rsp_cyc), 32'd0);
      check("rstm.mem", mem[8], 32'h5555_6666);
      run("rstm.lhu", 1'b0, F3_HU, 32'h22, 32'h0);
      expect_op("rstm.lhu", 3, 32'h0000_5555, 1'b0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
